// File: rtl/apb_slave_regfile.sv
// APB4 completer holding a word-addressed register file with programmable wait states.
// Optional: define APB_SLV_IDREG_EN to make register 0 a read-only ID register returning ID_VALUE.
module apb_slave_regfile #(
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned REG_NUM     = 16,
   parameter int unsigned WAIT_CYCLES = 2,
   parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001
) (
   input  logic                    pclk_i,
   input  logic                    preset_i,
   input  logic [ADDR_WIDTH-1:0]   paddr_i,
   input  logic                    psel_i,
   input  logic                    penable_i,
   input  logic                    pwrite_i,
   input  logic [DATA_WIDTH-1:0]   pwdata_i,
   input  logic [DATA_WIDTH/8-1:0] pstrb_i,
   output logic [DATA_WIDTH-1:0]   prdata_o,
   output logic                    pready_o,
   output logic                    pslverr_o,
   output logic [15:0]             xfer_cnt_o
);

   localparam int unsigned           STRB_W     = DATA_WIDTH / 8;
   localparam int unsigned           IDX_W      = $clog2(REG_NUM);
   localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(4 * REG_NUM);
   localparam logic [3:0]            WAIT_MAX   = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } state_e;

   state_e                  state_q, state_d, phase;
   logic [3:0]              cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    write_q, write_d;
   logic [15:0]             xfer_cnt_q, xfer_cnt_d;
   logic [DATA_WIDTH-1:0]   regs_q [REG_NUM];
   logic [DATA_WIDTH-1:0]   regs_d [REG_NUM];
   logic [IDX_W-1:0]        idx;
   logic                    pready;
   logic                    err;

   // The setup phase is recognised in the cycle it is on the bus, so a zero-wait transfer takes two cycles.
   always_comb begin
      phase = state_q;
      if ((state_q == IDLE) && psel_i && !penable_i) begin
         phase = SETUP;
      end
   end

   assign pready = (phase == ACCESS) && psel_i && penable_i && (cnt_q == WAIT_MAX);
   assign idx    = addr_q[2 +: IDX_W];

   always_comb begin
      err = (addr_q[1:0] != 2'b00) || (addr_q >= ADDR_LIMIT) || (!write_q && (pstrb_i != '0));
`ifdef APB_SLV_IDREG_EN
      if (write_q && (idx == '0)) begin
         err = 1'b1;
      end
`endif
   end

   // NOTE: every variable gets its default first so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = phase;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      case (phase)
         IDLE: begin
            state_d = IDLE;
         end
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = '0;
            addr_d  = paddr_i;
            write_d = pwrite_i;
         end
         ACCESS: begin
            if (!psel_i || pready) begin
               state_d = IDLE;
            end else if (cnt_q < WAIT_MAX) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      regs_d = regs_q;
      if (pready && write_q && !err) begin
         for (int k = 0; k < STRB_W; k++) begin
            if (pstrb_i[k]) begin
               regs_d[idx][8*k +: 8] = pwdata_i[8*k +: 8];
            end
         end
      end
   end

   assign xfer_cnt_d = pready ? (xfer_cnt_q + 16'd1) : xfer_cnt_q;

   always_comb begin
      prdata_o = '0;
      if (pready && !write_q && !err) begin
         prdata_o = regs_q[idx];
`ifdef APB_SLV_IDREG_EN
         if (idx == '0) begin
            prdata_o = DATA_WIDTH'(ID_VALUE);
         end
`endif
      end
   end

   assign pready_o   = pready;
   assign pslverr_o  = pready && err;
   assign xfer_cnt_o = xfer_cnt_q;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge pclk_i or posedge preset_i) begin
      if (preset_i) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         write_q    <= 1'b0;
         xfer_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         write_q    <= write_d;
         xfer_cnt_q <= xfer_cnt_d;
      end
   end

   // NOTE: the register file is reset because software relies on zeros; it is built from flops, not a RAM.
   always_ff @(posedge pclk_i or posedge preset_i) begin
      if (preset_i) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: a 2-wait-state instance driven from a vector table and a
// zero-wait instance for back-to-back and abort sequences; honours APB_SLV_IDREG_EN when defined.
module tb_apb_slave_regfile;

   logic        pclk = 1'b0;
   logic        rst  = 1'b1;
   logic [31:0] paddr = '0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] pwdata = '0;
   logic [3:0]  pstrb = '0;
   logic        tgt = 1'b0;
   logic        psel_a, psel_b;
   logic [31:0] prdata_a, prdata_b;
   logic        pready_a, pready_b, pslverr_a, pslverr_b;
   logic [15:0] xfer_cnt_a, xfer_cnt_b;

   int n_pass  = 0;
   int n_total = 0;
   int cycles  = 0;

   assign psel_a = psel && !tgt;
   assign psel_b = psel && tgt;

   always #5 pclk = ~pclk;
   always @(posedge pclk) cycles <= cycles + 1;

   apb_slave_regfile #(.WAIT_CYCLES(2)) dut_a (
      .pclk_i(pclk), .preset_i(rst), .paddr_i(paddr), .psel_i(psel_a), .penable_i(penable),
      .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata_a),
      .pready_o(pready_a), .pslverr_o(pslverr_a), .xfer_cnt_o(xfer_cnt_a)
   );

   apb_slave_regfile #(.WAIT_CYCLES(0)) dut_b (
      .pclk_i(pclk), .preset_i(rst), .paddr_i(paddr), .psel_i(psel_b), .penable_i(penable),
      .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb), .prdata_o(prdata_b),
      .pready_o(pready_b), .pslverr_o(pslverr_b), .xfer_cnt_o(xfer_cnt_b)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Starts #1 after a rising edge and returns #1 after the completion edge, leaving the bus idle,
   // so consecutive calls form back-to-back transfers.
   task automatic xfer(input bit t, input bit wr, input logic [31:0] addr, input logic [31:0] alt_addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rdata, output logic err, output int waits);
      bit done;
      tgt = t; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
      @(negedge pclk);
      check("pready_in_setup", {31'd0, t ? pready_b : pready_a}, 32'd0);
      @(posedge pclk); #1;
      penable = 1'b1;
      paddr   = alt_addr;
      waits   = 0;
      done    = 1'b0;
      rdata   = 'x;
      err     = 1'bx;
      for (int c = 0; c < 40; c++) begin
         @(negedge pclk);
         if (t ? pready_b : pready_a) begin
            rdata = t ? prdata_b : prdata_a;
            err   = t ? pslverr_b : pslverr_a;
            done  = 1'b1;
         end
         @(posedge pclk); #1;
         if (done) break;
         waits++;
      end
      if (!done) check("pready_timeout", 32'd0, 32'd1);
      psel = 1'b0; penable = 1'b0;
   endtask

   function automatic vec_t mk(logic wr, logic [31:0] addr, logic [31:0] wdata, logic [3:0] strb,
                               logic [31:0] exp_rdata, logic exp_err, logic [15:0] exp_cnt);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.strb = strb;
      v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_cnt = exp_cnt;
      return v;
   endfunction

   logic [31:0] rd;
   logic        er;
   int          w;
   int          t0;
   bit          seen;
   logic        id_en;
   logic [31:0] reg0_exp;

   initial begin
`ifdef APB_SLV_IDREG_EN
      id_en    = 1'b1;
      reg0_exp = 32'hA5B0_0001;
`else
      id_en    = 1'b0;
      reg0_exp = 32'hCAFE_F00D;
`endif
      vecs[0]  = mk(1, 32'h08, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 16'd1);
      vecs[1]  = mk(0, 32'h08, 32'h0,         4'h0, 32'hDEAD_BEEF, 0, 16'd2);
      vecs[2]  = mk(1, 32'h04, 32'h1122_3344, 4'hF, 32'h0, 0, 16'd3);
      vecs[3]  = mk(1, 32'h04, 32'hAABB_CCDD, 4'h5, 32'h0, 0, 16'd4);
      vecs[4]  = mk(0, 32'h04, 32'h0,         4'h0, 32'h11BB_33DD, 0, 16'd5);
      vecs[5]  = mk(0, 32'h40, 32'h0,         4'h0, 32'h0, 1, 16'd6);
      vecs[6]  = mk(1, 32'h06, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 16'd7);
      vecs[7]  = mk(0, 32'h04, 32'h0,         4'h0, 32'h11BB_33DD, 0, 16'd8);
      vecs[8]  = mk(0, 32'h08, 32'h0,         4'h1, 32'h0, 1, 16'd9);
      vecs[9]  = mk(1, 32'h3C, 32'h1234_5678, 4'h8, 32'h0, 0, 16'd10);
      vecs[10] = mk(0, 32'h3C, 32'h0,         4'h0, 32'h1200_0000, 0, 16'd11);
      vecs[11] = mk(0, 32'h3D, 32'h0,         4'h0, 32'h0, 1, 16'd12);
      vecs[12] = mk(1, 32'h00, 32'hCAFE_F00D, 4'hF, 32'h0, id_en, 16'd13);
      vecs[13] = mk(0, 32'h00, 32'h0,         4'h0, reg0_exp, 0, 16'd14);
      vecs[14] = mk(0, 32'h8000_0008, 32'h0,  4'h0, 32'h0, 1, 16'd15);

      // Reset state, sampled while reset is held and again after release.
      repeat (2) @(posedge pclk);
      @(negedge pclk);
      check("rst_pready_a", {31'd0, pready_a}, 32'd0);
      check("rst_prdata_a", prdata_a, 32'd0);
      check("rst_pslverr_a", {31'd0, pslverr_a}, 32'd0);
      check("rst_cnt_a", {16'd0, xfer_cnt_a}, 32'd0);
      check("rst_cnt_b", {16'd0, xfer_cnt_b}, 32'd0);
      @(posedge pclk); #1;
      rst = 1'b0;
      @(negedge pclk);
      check("post_rst_pready_b", {31'd0, pready_b}, 32'd0);
      check("post_rst_prdata_b", prdata_b, 32'd0);
      @(posedge pclk); #1;

      for (int i = 0; i < 15; i++) begin
         xfer(0, vecs[i].wr, vecs[i].addr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, rd, er, w);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
         check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vecs[i].exp_err});
         check($sformatf("vec%0d_waits", i), w, 32'd2);
         check($sformatf("vec%0d_cnt", i), {16'd0, xfer_cnt_a}, {16'd0, vecs[i].exp_cnt});
      end

      // Back-to-back zero-wait writes: three 2-cycle transfers with no idle cycle between them.
      t0 = cycles;
      xfer(1, 1, 32'h00, 32'h00, 32'h1111_1111, 4'hF, rd, er, w);
      check("b2b_w0_err", {31'd0, er}, {31'd0, id_en});
      check("b2b_w0_waits", w, 32'd0);
      xfer(1, 1, 32'h04, 32'h04, 32'h2222_2222, 4'hF, rd, er, w);
      check("b2b_w1_waits", w, 32'd0);
      xfer(1, 1, 32'h08, 32'h08, 32'h3333_3333, 4'hF, rd, er, w);
      check("b2b_w2_waits", w, 32'd0);
      check("b2b_cycles", cycles - t0, 32'd6);
      check("b2b_cnt_w", {16'd0, xfer_cnt_b}, 32'd3);
      xfer(1, 0, 32'h00, 32'h00, 32'h0, 4'h0, rd, er, w);
      check("b2b_r0", rd, id_en ? 32'hA5B0_0001 : 32'h1111_1111);
      xfer(1, 0, 32'h04, 32'h04, 32'h0, 4'h0, rd, er, w);
      check("b2b_r1", rd, 32'h2222_2222);
      xfer(1, 0, 32'h08, 32'h08, 32'h0, 4'h0, rd, er, w);
      check("b2b_r2", rd, 32'h3333_3333);
      check("b2b_cnt_r", {16'd0, xfer_cnt_b}, 32'd6);

      // psel dropped in the first access cycle: no completion, no write, no count.
      tgt = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0C; pwdata = 32'h5; pstrb = 4'hF;
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b1;
      @(negedge pclk);
      check("abort_pready", {31'd0, pready_b}, 32'd0);
      @(posedge pclk); #1;
      penable = 1'b0;
      @(posedge pclk); #1;
      check("abort_cnt", {16'd0, xfer_cnt_b}, 32'd6);
      xfer(1, 0, 32'h0C, 32'h0C, 32'h0, 4'h0, rd, er, w);
      check("abort_reg", rd, 32'h0);
      check("abort_cnt_after_read", {16'd0, xfer_cnt_b}, 32'd7);

      // penable high while idle is ignored.
      tgt = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h08; pstrb = 4'h0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge pclk);
         if (pready_a) seen = 1'b1;
      end
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      check("idle_penable_pready", {31'd0, seen}, 32'd0);
      check("idle_penable_cnt", {16'd0, xfer_cnt_a}, 32'd15);

      // Address changed during the access phase: the setup-phase address is used.
      xfer(0, 1, 32'h10, 32'h14, 32'h0BAD_CAFE, 4'hF, rd, er, w);
      check("addr_chg_err", {31'd0, er}, 32'd0);
      xfer(0, 0, 32'h10, 32'h10, 32'h0, 4'h0, rd, er, w);
      check("addr_chg_r10", rd, 32'h0BAD_CAFE);
      xfer(0, 0, 32'h14, 32'h14, 32'h0, 4'h0, rd, er, w);
      check("addr_chg_r14", rd, 32'h0);
      check("addr_chg_cnt", {16'd0, xfer_cnt_a}, 32'd18);

      // Reset asserted in the middle of a wait-stated write.
      tgt = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h18; pwdata = 32'h55; pstrb = 4'hF;
      @(posedge pclk); #1;
      penable = 1'b1;
      @(posedge pclk); #1;
      rst = 1'b1;
      #1;
      check("midrst_pready", {31'd0, pready_a}, 32'd0);
      check("midrst_cnt", {16'd0, xfer_cnt_a}, 32'd0);
      @(posedge pclk); #1;
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      @(posedge pclk); #1;
      xfer(0, 0, 32'h18, 32'h18, 32'h0, 4'h0, rd, er, w);
      check("midrst_reg", rd, 32'h0);
      xfer(0, 0, 32'h08, 32'h08, 32'h0, 4'h0, rd, er, w);
      check("midrst_reg_cleared", rd, 32'h0);
      check("midrst_cnt_after", {16'd0, xfer_cnt_a}, 32'd2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed so far", n_pass, n_total);
      $fatal(1);
   end

endmodule
